// File: rtl/hazard_scoreboard_pkg.sv
// Shared MIPS opcode/function encodings and scoreboard helpers for the ID-stage
// register-hazard scoreboard.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL     = 6'd0;
    localparam logic [5:0] FN_SRL     = 6'd2;
    localparam logic [5:0] FN_SRA     = 6'd3;
    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_SYSCALL = 6'd12;
    localparam logic [5:0] FN_ADD     = 6'd32;
    localparam logic [5:0] FN_ADDU    = 6'd33;
    localparam logic [5:0] FN_SUB     = 6'd34;
    localparam logic [5:0] FN_AND     = 6'd36;
    localparam logic [5:0] FN_OR      = 6'd37;
    localparam logic [5:0] FN_NOR     = 6'd39;
    localparam logic [5:0] FN_SLT     = 6'd42;
    localparam logic [5:0] FN_SLTU    = 6'd43;

    // Link register written by jal.
    localparam int REG_RA = 31;

    // Slot layout with the widest fields any configuration needs; the top
    // narrows dest/lat to its own REG_W/LAT_W when it builds its slot type.
    localparam int SLOT_DEST_MAX_W = 8;
    localparam int SLOT_LAT_MAX_W  = 8;

    typedef struct packed {
        logic                       valid;
        logic [SLOT_DEST_MAX_W-1:0] dest;
        logic [SLOT_LAT_MAX_W-1:0]  lat;
    } slot_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage bundle between the pipeline control (master) and the hazard
// scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);

    logic             id_valid;
    logic [5:0]       id_op;
    logic [5:0]       id_func;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             pipe_en;
    logic             flush;

    logic             stall;
    logic             r1_used;
    logic             r2_used;
    logic             hazard_a;
    logic             hazard_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_op, id_func, id_rs, id_rt, id_rd, pipe_en, flush,
        input  stall, r1_used, r2_used, hazard_a, hazard_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_op, id_func, id_rs, id_rt, id_rd, pipe_en, flush,
        output stall, r1_used, r2_used, hazard_a, hazard_b, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard_reg_src_dst_decode.sv
// Combinational decode of which register fields an instruction reads and
// which register (if any) it writes.
module reg_src_dst_decode
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output logic             r1_used,
    output logic             r2_used,
    output logic             dest_valid,
    output logic [REG_W-1:0] dest,
    output logic             is_load
);

    logic             writes;
    logic [REG_W-1:0] dest_raw;

    always_comb begin
        r1_used  = 1'b0;
        r2_used  = 1'b0;
        writes   = 1'b0;
        dest_raw = '0;
        if (op == OP_RTYPE) begin
            case (func)
                FN_JR: r1_used = 1'b1;
                FN_SYSCALL, FN_ADD, FN_ADDU, FN_SUB, FN_AND,
                FN_OR, FN_NOR, FN_SLT, FN_SLTU: begin
                    r1_used = 1'b1;
                    r2_used = 1'b1;
                end
                FN_SLL, FN_SRL, FN_SRA: r2_used = 1'b1;
                default: ;
            endcase
            writes   = (func != FN_JR) && (func != FN_SYSCALL);
            dest_raw = rd;
        end else begin
            case (op)
                OP_BEQ, OP_BNE, OP_SW: begin
                    r1_used = 1'b1;
                    r2_used = 1'b1;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
                    r1_used  = 1'b1;
                    writes   = 1'b1;
                    dest_raw = rt;
                end
                OP_JAL: begin
                    writes   = 1'b1;
                    dest_raw = REG_W'(REG_RA);
                end
                default: ;
            endcase
        end
    end

    // $zero is hard-wired, so a write to it never creates a dependence.
    assign dest_valid = writes && (dest_raw != '0);
    assign dest       = dest_raw;
    assign is_load    = (op == OP_LW);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage register-hazard scoreboard: tracks in-flight destinations through
// the downstream stages and stalls ID until its sources can be supplied.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 3,
    parameter int FORWARD  = 1,
    parameter int LOAD_LAT = 2,
    parameter int ALU_LAT  = 1,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  bus
);

    localparam int REG_W = $clog2(NUM_REGS);
    localparam int LAT_W = $clog2(max_int(LOAD_LAT, ALU_LAT) + 1);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic [LAT_W-1:0] lat;
    } slot_entry_t;

    slot_entry_t      slot_q [DEPTH];
    slot_entry_t      slot_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             r1_used;
    logic             r2_used;
    logic             dest_valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
    logic             hazard_a;
    logic             hazard_b;
    logic             stall;
    logic             issue;

    reg_src_dst_decode #(.REG_W(REG_W)) u_decode (
        .op         (bus.id_op),
        .func       (bus.id_func),
        .rt         (bus.id_rt),
        .rd         (bus.id_rd),
        .r1_used    (r1_used),
        .r2_used    (r2_used),
        .dest_valid (dest_valid),
        .dest       (dest),
        .is_load    (is_load)
    );

    // The last slot is writing back this cycle and the register file is
    // write-before-read, so only slots 0..DEPTH-2 can block a source.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i <= DEPTH - 2; i++) begin
            if (slot_q[i].valid && ((FORWARD == 0) || (slot_q[i].lat != '0))) begin
                if (r1_used && (bus.id_rs != '0) && (bus.id_rs == slot_q[i].dest))
                    hazard_a = 1'b1;
                if (r2_used && (bus.id_rt != '0) && (bus.id_rt == slot_q[i].dest))
                    hazard_b = 1'b1;
            end
        end
    end

    assign stall = bus.id_valid && !bus.flush && (hazard_a || hazard_b);
    assign issue = bus.id_valid && !stall && !bus.flush;

    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (bus.pipe_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot_d[i] = slot_q[i-1];
                if (slot_q[i-1].lat != '0)
                    slot_d[i].lat = slot_q[i-1].lat - 1'b1;
            end
            // A stalled or flushed ID leaves a bubble behind it.
            slot_d[0].valid = issue && dest_valid;
            slot_d[0].dest  = issue ? dest : '0;
            slot_d[0].lat   = !issue ? '0 :
                              is_load ? LAT_W'(LOAD_LAT - 1) : LAT_W'(ALU_LAT - 1);
            if (stall && (cnt_q != '1))
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                slot_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.r1_used   = r1_used;
    assign bus.r2_used   = r2_used;
    assign bus.hazard_a  = hazard_a;
    assign bus.hazard_b  = hazard_b;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register-hazard scoreboard for the ID stage of the pipelined MIPS core. It decodes source usage and destination of the instruction in ID, tracks in-flight destinations through the downstream stages, and raises `stall` when a source is not yet available. Forward-capable and non-forwarding modes and configurable load latency are supported. A saturating stall counter is kept for performance monitoring.

## Interface

Parameters:

- `NUM_REGS`, 32: architectural registers; `REG_W = $clog2(NUM_REGS)`.
- `DEPTH`, 3: in-flight slots after ID (EX, MEM, WB); minimum 2.
- `FORWARD`, 1: 1 = bypass network present; 0 = wait for write-back.
- `LOAD_LAT`, 2: cycles from EX entry until load data is forwardable; minimum 1.
- `ALU_LAT`, 1: same, for all non-load writers; minimum 1.
- `CNT_W`, 32: stall counter width.

Ports:

- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_op`, in, 6: opcode.
- `id_func`, in, 6: function field.
- `id_rs`, `id_rt`, `id_rd`, in, REG_W: register fields.
- `pipe_en`, in, 1: pipeline advances this cycle.
- `flush`, in, 1: kill the ID instruction (taken branch).
- `stall`, out, 1: hold PC/IF/ID and inject a bubble.
- `r1_used`, `r2_used`, out, 1: rs/rt read by the ID instruction.
- `hazard_a`, `hazard_b`, out, 1: rs/rt unresolved dependence.
- `stall_cnt`, out, CNT_W: stalled cycles, saturating.

## Operation

- Source decode:
  - `r1_used` when OP=0 and Func ∈ {8,12,32,33,34,36,37,39,42,43}, or when OP ∈ {4,5,8,9,10,12,13,35,43}.
  - `r2_used` when OP=0 and Func ∈ {0,2,3,12,32,33,34,36,37,39,42,43}, or when OP ∈ {4,5,43}.
- Destination decode:
  - OP=0 with Func ∉ {8,12}: `id_rd`.
  - OP ∈ {8,9,10,12,13,35}: `id_rt`.
  - OP=3: register 31.
  - Otherwise: no write. A destination of register 0 is treated as no write.
- Slot fields: `valid`, `dest`, `lat`. `lat` width is `$clog2(max(LOAD_LAT,ALU_LAT)+1)`.
- On issue, the new instruction enters slot 0 with `lat = LOAD_LAT-1` if OP=35, otherwise `ALU_LAT-1`.
- Hazard on a source: the source is used, is nonzero, and matches `dest` of a valid slot i with i ≤ DEPTH-2, where:
  - FORWARD=1: additionally requires `lat`≠0.
  - FORWARD=0: any match.
- Slot DEPTH-1 never causes a hazard; the register file is write-before-read.
- `stall = id_valid & ~flush & (hazard_a | hazard_b)`. This is combinational from slot state and ID inputs.
- Advance when `pipe_en`=1:
  - slot[i+1] ← slot[i] with `lat` decremented, saturating at 0.
  - slot[DEPTH-1] retires.
  - slot[0] ← ID instruction if `id_valid & ~stall & ~flush`, else a bubble (valid=0).
- `pipe_en`=0: all slots and `stall_cnt` hold; `stall` is still evaluated.
- `stall_cnt` increments when `stall & pipe_en`; it saturates at all-ones.

## Timing

- Reset (async assert, sync release): all slots invalid, `stall_cnt`=0. Hence `stall`=0 and `hazard_a`/`hazard_b`=0. `r1_used`/`r2_used` follow their inputs.
- Decode and hazard outputs have zero-cycle latency from ID inputs. Slot update and counter take effect at the next rising `clk`.
- Load-use stall length:
  - FORWARD=1: `LOAD_LAT-1` cycles.
  - ALU-use with `ALU_LAT`=1: no stall.
  - FORWARD=0: producer immediately ahead stalls DEPTH-1 cycles.
- Flush and hazard in the same cycle: `stall`=0, a bubble enters slot 0, the counter does not increment.
- Reset mid-stall: in-flight state is discarded immediately; no residual stall.

## Structure

- Package `hazard_pkg`:
  - opcode/func constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_JAL, FN_JR, FN_SYSCALL, etc.
  - register 31 constant.
  - slot struct typedef.
- Sub-module `reg_src_dst_decode`: combinational; produces `r1_used`, `r2_used`, `dest_valid`, `dest`, `is_load`.

## Test plan

- Reset mid-operation: lw $8 in slot 0, dependent add in ID, pulse `rst_n` low → `stall`=0 immediately; `stall_cnt`=0; slots empty after release.
- FORWARD=1: lw $8,0($9) then add $10,$8,$11 back-to-back → `stall`=1 for exactly 1 cycle, `hazard_a`=1, then issue; `stall_cnt`=1.
- FORWARD=1: add $8,$1,$2 then sub $9,$8,$8 → no stall; `hazard_a`/`hazard_b` stay 0.
- FORWARD=0, DEPTH=3: add $8 then beq $8,$0 → `stall`=1 for 2 cycles, `hazard_a`=1, `hazard_b`=0; `stall_cnt`=2.
- addi $0,$1,5 then add $2,$0,$0 → no stall (register 0 is never a hazard).
- lw $8 in slot 0, dependent in ID:
  - `pipe_en`=0 for 3 cycles → `stall` held 1, slots and counter frozen.
  - Then `flush`=1 → `stall`=0, bubble enters slot 0.
